// File: rtl/move_sequencer.sv
// Turn-based move controller: turns mouse clicks into board pick/place strobes,
// gates placement with the generator's legal-move mask and detects king capture.
module move_sequencer #(
    parameter int GEN_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_click,
    input  logic [5:0]  i_cursor_pos,
    input  logic [3:0]  i_square_code,
    input  logic        i_moves_valid,
    input  logic [63:0] i_possible_moves,
    output logic        o_pick_piece,
    output logic        o_place_piece,
    output logic [5:0]  o_figure_position,
    output logic        o_gen_start,
    output logic [5:0]  o_src_pos,
    output logic [63:0] o_moves_mask,
    output logic        o_turn,
    output logic        o_game_over,
    output logic        o_winner
);

    typedef enum logic [2:0] {
        S_SELECT,
        S_PICK,
        S_GEN,
        S_TARGET,
        S_PLACE,
        S_CANCEL,
        S_OVER
    } state_t;

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(GEN_TIMEOUT - 1);
    localparam logic [3:0]      WHITE_KING = 4'd6;
    localparam logic [3:0]      BLACK_KING = 4'd12;

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [5:0]      r_dst;
    logic [3:0]      r_captured;

    logic w_white_piece;
    logic w_black_piece;
    logic w_own_piece;
    logic w_in_mask;
    logic w_king_taken;

    assign w_white_piece = (i_square_code >= 4'd1) && (i_square_code <= 4'd6);
    assign w_black_piece = (i_square_code >= 4'd7) && (i_square_code <= 4'd12);
    assign w_own_piece   = o_turn ? w_black_piece : w_white_piece;
    assign w_in_mask     = o_moves_mask[i_cursor_pos];
    assign w_king_taken  = (r_captured == WHITE_KING) || (r_captured == BLACK_KING);

    // Generator wait is a down-counter loaded in PICK; zero is the terminal count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= S_SELECT;
            r_cnt             <= '0;
            r_dst             <= '0;
            r_captured        <= '0;
            o_pick_piece      <= 1'b0;
            o_place_piece     <= 1'b0;
            o_figure_position <= '0;
            o_gen_start       <= 1'b0;
            o_src_pos         <= '0;
            o_moves_mask      <= '0;
            o_turn            <= 1'b0;
            o_game_over       <= 1'b0;
            o_winner          <= 1'b0;
        end else begin
            o_pick_piece  <= 1'b0;
            o_place_piece <= 1'b0;
            o_gen_start   <= 1'b0;
            unique case (r_state)
                S_SELECT: begin
                    if (i_click && w_own_piece) begin
                        o_src_pos <= i_cursor_pos;
                        r_state   <= S_PICK;
                    end
                end
                S_PICK: begin
                    o_pick_piece      <= 1'b1;
                    o_figure_position <= o_src_pos;
                    o_gen_start       <= 1'b1;
                    r_cnt             <= TO_LOAD;
                    r_state           <= S_GEN;
                end
                S_GEN: begin
                    if (i_moves_valid) begin
                        o_moves_mask <= i_possible_moves;
                        r_state      <= S_TARGET;
                    end else if (r_cnt == '0) begin
                        r_state <= S_CANCEL;
                    end else begin
                        r_cnt <= r_cnt - TO_W'(1);
                    end
                end
                S_TARGET: begin
                    if (i_click) begin
                        if (i_cursor_pos == o_src_pos) begin
                            r_state <= S_CANCEL;
                        end else if (w_in_mask) begin
                            r_dst      <= i_cursor_pos;
                            r_captured <= i_square_code;
                            r_state    <= S_PLACE;
                        end
                    end
                end
                S_PLACE: begin
                    o_place_piece     <= 1'b1;
                    o_figure_position <= r_dst;
                    o_moves_mask      <= '0;
                    o_turn            <= ~o_turn;
                    if (w_king_taken) begin
                        o_game_over <= 1'b1;
                        o_winner    <= o_turn;
                        r_state     <= S_OVER;
                    end else begin
                        r_state <= S_SELECT;
                    end
                end
                S_CANCEL: begin
                    o_place_piece     <= 1'b1;
                    o_figure_position <= o_src_pos;
                    o_moves_mask      <= '0;
                    r_state           <= S_SELECT;
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_SELECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: full moves, ignored clicks, cancel,
// generator timeout, valid-at-terminal-count and king capture with reset.
module tb_move_sequencer;

    logic        clk_sys;
    logic        rst;
    logic        click;
    logic [5:0]  cursor_pos;
    logic [3:0]  square_code;
    logic        moves_valid;
    logic [63:0] possible_moves;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  figure_position;
    logic        gen_start;
    logic [5:0]  src_pos;
    logic [63:0] moves_mask;
    logic        turn;
    logic        game_over;
    logic        winner;

    int n_checks = 0;
    int n_fail   = 0;

    move_sequencer #(.GEN_TIMEOUT(4), .TO_W(8)) dut (
        .i_clk            (clk_sys),
        .i_rst            (rst),
        .i_click          (click),
        .i_cursor_pos     (cursor_pos),
        .i_square_code    (square_code),
        .i_moves_valid    (moves_valid),
        .i_possible_moves (possible_moves),
        .o_pick_piece     (pick_piece),
        .o_place_piece    (place_piece),
        .o_figure_position(figure_position),
        .o_gen_start      (gen_start),
        .o_src_pos        (src_pos),
        .o_moves_mask     (moves_mask),
        .o_turn           (turn),
        .o_game_over      (game_over),
        .o_winner         (winner)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Click for one cycle, then wait one more so the pick strobe is visible.
    task automatic click_and_pick(input logic [5:0] pos, input logic [3:0] code);
        click       = 1'b1;
        cursor_pos  = pos;
        square_code = code;
        tick();
        click = 1'b0;
        tick();
    endtask

    task automatic click_once(input logic [5:0] pos, input logic [3:0] code);
        click       = 1'b1;
        cursor_pos  = pos;
        square_code = code;
        tick();
        click = 1'b0;
    endtask

    task automatic gen_done(input logic [63:0] mask);
        moves_valid    = 1'b1;
        possible_moves = mask;
        tick();
        moves_valid    = 1'b0;
        possible_moves = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        click          = 1'b0;
        cursor_pos     = '0;
        square_code    = '0;
        moves_valid    = 1'b0;
        possible_moves = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_pick",  {63'd0, pick_piece}, 64'd0);
        check("rst_place", {63'd0, place_piece}, 64'd0);
        check("rst_fig",   {58'd0, figure_position}, 64'd0);
        check("rst_turn",  {63'd0, turn}, 64'd0);
        check("rst_over",  {63'd0, game_over}, 64'd0);
        check("rst_mask",  moves_mask, 64'd0);

        // White pawn (6,4)=52 to 36.
        click_once(6'd52, 4'd1);
        check("lat1_pick", {63'd0, pick_piece}, 64'd0);
        tick();
        check("w_pick",      {63'd0, pick_piece}, 64'd1);
        check("w_pick_fig",  {58'd0, figure_position}, 64'd52);
        check("w_gen_start", {63'd0, gen_start}, 64'd1);
        check("w_src",       {58'd0, src_pos}, 64'd52);
        gen_done(64'd1 << 36);
        check("w_pick_1cyc", {63'd0, pick_piece}, 64'd0);
        check("w_gen_1cyc",  {63'd0, gen_start}, 64'd0);
        check("w_mask",      moves_mask, 64'd1 << 36);
        click_once(6'd36, 4'd0);
        check("w_lat1_place", {63'd0, place_piece}, 64'd0);
        tick();
        check("w_place",     {63'd0, place_piece}, 64'd1);
        check("w_place_fig", {58'd0, figure_position}, 64'd36);
        check("w_turn",      {63'd0, turn}, 64'd1);
        check("w_mask_clr",  moves_mask, 64'd0);
        tick();
        check("w_place_1cyc", {63'd0, place_piece}, 64'd0);
        check("fig_hold",     {58'd0, figure_position}, 64'd36);

        // Black to move: white piece and code D are not own pieces.
        click_and_pick(6'd10, 4'd1);
        check("b_white_ign", {63'd0, pick_piece}, 64'd0);
        click_and_pick(6'd11, 4'd13);
        check("b_codeD_ign", {63'd0, pick_piece}, 64'd0);
        click_and_pick(6'd8, 4'd7);
        check("b_pick",     {63'd0, pick_piece}, 64'd1);
        check("b_pick_fig", {58'd0, figure_position}, 64'd8);

        // No moves_valid: GEN lasts 4 cycles, then CANCEL strobes.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_wait", {63'd0, place_piece}, 64'd0);
        end
        tick();
        check("to_place", {63'd0, place_piece}, 64'd1);
        check("to_fig",   {58'd0, figure_position}, 64'd8);
        check("to_turn",  {63'd0, turn}, 64'd1);

        // Black again: off-mask click ignored, click on source cancels.
        click_and_pick(6'd8, 4'd7);
        check("c_pick", {63'd0, pick_piece}, 64'd1);
        gen_done(64'd1 << 36);
        click_once(6'd20, 4'd0);
        tick();
        check("c_offmask", {63'd0, place_piece}, 64'd0);
        check("c_mask_kept", moves_mask, 64'd1 << 36);
        click_once(6'd8, 4'd7);
        tick();
        check("c_place",    {63'd0, place_piece}, 64'd1);
        check("c_fig",      {58'd0, figure_position}, 64'd8);
        check("c_turn",     {63'd0, turn}, 64'd1);
        check("c_mask_clr", moves_mask, 64'd0);

        // Black completes a move 8 -> 36.
        click_and_pick(6'd8, 4'd7);
        gen_done(64'd1 << 36);
        click_once(6'd36, 4'd1);
        tick();
        check("b_place", {63'd0, place_piece}, 64'd1);
        check("b_turn",  {63'd0, turn}, 64'd0);
        tick();

        // White: moves_valid arrives on the terminal-count cycle and wins.
        click_and_pick(6'd52, 4'd1);
        check("k_pick", {63'd0, pick_piece}, 64'd1);
        tick();
        tick();
        tick();
        gen_done(64'd1 << 4);
        check("k_valid_wins", moves_mask, 64'd1 << 4);
        tick();
        check("k_no_cancel", {63'd0, place_piece}, 64'd0);
        click_once(6'd4, 4'd12);
        tick();
        check("k_place",  {63'd0, place_piece}, 64'd1);
        check("k_over",   {63'd0, game_over}, 64'd1);
        check("k_winner", {63'd0, winner}, 64'd0);
        check("k_turn",   {63'd0, turn}, 64'd1);
        click_and_pick(6'd9, 4'd7);
        tick();
        check("o_pick",  {63'd0, pick_piece}, 64'd0);
        check("o_place", {63'd0, place_piece}, 64'd0);
        check("o_sticky", {63'd0, game_over}, 64'd1);

        rst = 1'b1;
        #1;
        check("r_over_async", {63'd0, game_over}, 64'd0);
        check("r_turn_async", {63'd0, turn}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        click_and_pick(6'd52, 4'd1);
        check("r_pick_after", {63'd0, pick_piece}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Turn-based move controller that sits between mouse/cursor logic, the move generator and the 8x8 board register file.
- Converts mouse clicks into the board's one-cycle pick/place strobes and gates placement with the generator's legal-move mask.
- Alternates white/black turns, supports cancelling a pick, and detects king capture to end the game.

Parameters:
- GEN_TIMEOUT, 255, max cycles to wait for moves_valid after gen_start before auto-cancel
- TO_W, 8, width of timeout counter; must hold GEN_TIMEOUT

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- click  in  1  one-cycle pulse, left mouse button press
- cursor_pos  in  6  square under cursor, [5:3] row, [2:0] column
- square_code  in  4  piece code at cursor_pos in the same cycle; upstream registers both together
- moves_valid  in  1  generator done; possible_moves stable while high
- possible_moves  in  64  legal-destination mask, bit index = {row,col}
- pick_piece  out  1  one-cycle strobe to board
- place_piece  out  1  one-cycle strobe to board
- figure_position  out  6  square addressed by pick/place strobe
- gen_start  out  1  one-cycle pulse to move generator
- src_pos  out  6  square of the held piece
- moves_mask  out  64  latched mask for highlight; 0 when no piece held
- turn  out  1  0 = white to move, 1 = black
- game_over  out  1  sticky once a king is captured
- winner  out  1  side that captured the king; valid when game_over

Behaviour:
- Piece codes: 0 empty; 1-6 white (6 king); 7-C black (C king); D and above are treated as empty.
- Own piece: white → 1..6 when turn=0; black → 7..C when turn=1.
- Reset values: all outputs 0; state = SELECT; internal target code register 0.
- All outputs are registered; strobes are high for exactly one cycle.

FSM states and transitions:
- SELECT
  - click with an own piece → PICK; latch src_pos=cursor_pos.
  - click on empty or opponent piece: ignored.
- PICK: pick_piece=1, figure_position=src_pos, gen_start=1 → GEN; clear timeout counter.
- GEN
  - moves_valid=1 → latch moves_mask=possible_moves → TARGET.
  - otherwise increment counter; at GEN_TIMEOUT → CANCEL.
  - click ignored.
- TARGET
  - click with cursor_pos==src_pos → CANCEL.
  - click with moves_mask[cursor_pos]=1 → PLACE; latch dst=cursor_pos and captured=square_code.
  - any other click is ignored.
- PLACE
  - place_piece=1, figure_position=dst, moves_mask←0, turn toggles.
  - captured code is 6 or C → game_over=1, winner=turn (pre-toggle value) → OVER; else → SELECT.
- CANCEL: place_piece=1, figure_position=src_pos, moves_mask←0, turn unchanged → SELECT.
- OVER: terminal; clicks ignored; only rst exits.

Timing and boundaries:
- Latency click → pick_piece: 2 cycles (click registered in SELECT, strobe in PICK).
- Latency TARGET click → place_piece: 2 cycles.
- Minimum full move: 5 cycles plus generator time.
- A click in the same cycle as a state change is evaluated only in the state it arrives in; no click queuing.
- moves_valid arriving in the same cycle as the timeout terminal count: moves_valid wins.
- An all-zero mask is legal: only cancel is possible.
- rst mid-move (any state): immediate return to reset values. The board is reset by the same rst, so no piece is lost.
- figure_position holds its last value outside strobe cycles.

Test Plan:
- Reset, turn=0; click (6,4) with code 1; moves_valid with mask bit 36 → pick_piece at cycle+2 with pos 52; gen_start=1; click cursor 36 → place_piece pos 36; turn=1.
- turn=1, click a white square (code 1) → no pick_piece, state stays SELECT; then click code 7 at pos 8 → pick_piece, figure_position=8.
- After pick at pos 52, click pos 52 in TARGET → place_piece pos 52; turn unchanged; moves_mask=0.
- In TARGET with mask bit 36 only, click pos 20 → nothing; click 36 → place.
- GEN_TIMEOUT=4, moves_valid never asserted → place_piece at src_pos 4 cycles after GEN entry; turn unchanged.
- White places on a square with square_code=C → game_over=1, winner=0; further clicks produce no strobes; rst asserted mid-OVER clears game_over and turn.
